// File: rtl/full_adder_pkg.sv
// Shared constants and the result payload type for the full_adder block.
package full_adder_pkg;

    localparam int unsigned FA_DEFAULT_WIDTH = 1;
    localparam int unsigned FA_MAX_WIDTH     = 64;

    // Widest possible result; each instance declares its own WIDTH-sized copy.
    typedef struct packed {
        logic                    carry;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_max_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// 1-bit combinational full adder, the ripple element of full_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {carry, sum} = a + b + c, one cycle latency.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } result_t;

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH out of range 1..64");
    end

    logic [WIDTH:0]   chain_w;   // chain_w[i] is the carry into cell i
    logic [WIDTH-1:0] sum_w;
    result_t          res_d;
    result_t          res_q;
    logic             valid_d;
    logic             valid_q;

    assign chain_w[0] = c;

    // Ripple chain of 1-bit cells, LSB first.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (chain_w[i]),
            .s    (sum_w[i]),
            .cout (chain_w[i+1])
        );
    end

`ifdef FULL_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = chain_w[WIDTH-1] ^ chain_w[WIDTH];
        end
    end

    // Overflow flag register, captured alongside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Capture the core result only on accepted inputs, so X on idle inputs never lands.
    always_comb begin
        res_d   = res_q;
        valid_d = in_valid;
        if (in_valid) begin
            res_d.carry = chain_w[WIDTH];
            res_d.sum   = sum_w;
        end
    end

    // Output register stage; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = res_q.sum;
    assign carry     = res_q.carry;
    assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic       iv1, a1, b1, c1;
    logic       s1, co1, ov1;

    logic       iv8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, ov8;

`ifdef FULL_ADDER_OVF_EN
    logic       of1, of8;
`endif

    int n_vec;
    int n_err;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .sum       (s1),
        .carry     (co1),
`ifdef FULL_ADDER_OVF_EN
        .ovf       (of1),
`endif
        .out_valid (ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .sum       (s8),
        .carry     (co8),
`ifdef FULL_ADDER_OVF_EN
        .ovf       (of8),
`endif
        .out_valid (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({ov1, co1, s1} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_w1[%0d]: got v/c/s=%b expected 000", i, {ov1, co1, s1});
            end
            n_vec++;
            if ({ov8, co8, s8} !== 10'h000) begin
                n_err++;
                $display("FAIL reset_w8[%0d]: got v/c/s=%b expected 0", i, {ov8, co8, s8});
            end
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({ov1, co1, s1} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_release_w1: got v/c/s=%b expected 111", {ov1, co1, s1});
        end
        n_vec++;
        if (ov8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_w8_valid: got %b expected 0", ov8);
        end
    endtask

    task automatic test_truth_table();
        // {carry,sum} for {a,b,c} = 0..7
        logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            iv1 = 1'b1;
            {a1, b1, c1} = v;
            step();
            n_vec++;
            if ({ov1, co1, s1} !== {1'b1, tt[i]}) begin
                n_err++;
                $display("FAIL truth_%b: got v/c/s=%b expected %b", v, {ov1, co1, s1}, {1'b1, tt[i]});
            end
        end
    endtask

    task automatic test_hold();
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        step();
        n_vec++;
        if ({ov1, co1, s1} !== 3'b110) begin
            n_err++;
            $display("FAIL hold_accept: got v/c/s=%b expected 110", {ov1, co1, s1});
        end
        for (int i = 0; i < 3; i++) begin
            iv1 = 1'b0;
            a1 = 1'($urandom);
            b1 = (i == 1) ? 1'bx : 1'($urandom);
            c1 = (i == 2) ? 1'bz : 1'($urandom);
            step();
            n_vec++;
            if ({ov1, co1, s1} !== 3'b010) begin
                n_err++;
                $display("FAIL hold[%0d]: got v/c/s=%b expected 010", i, {ov1, co1, s1});
            end
        end
    endtask

    task automatic test_wrap_w8();
        // a, b, c, expected carry, sum, ovf
        logic [7:0] ta [5] = '{8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h12};
        logic [7:0] tb [5] = '{8'h00, 8'h80, 8'h01, 8'h01, 8'h34};
        logic       tc [5] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        logic [8:0] tr [5] = '{9'h100, 9'h100, 9'h080, 9'h100, 9'h047};
        logic       to [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
            step();
            n_vec++;
            if ({ov8, co8, s8} !== {1'b1, tr[i]}) begin
                n_err++;
                $display("FAIL w8_vec%0d: got v/c/s=%h expected %h", i, {ov8, co8, s8}, {1'b1, tr[i]});
            end
`ifdef FULL_ADDER_OVF_EN
            n_vec++;
            if (of8 !== to[i]) begin
                n_err++;
                $display("FAIL w8_ovf%0d: got %b expected %b", i, of8, to[i]);
            end
`else
            if (to[i] === 1'bx) $display("unexpected table entry");
`endif
        end
        iv8 = 1'b0;
    endtask

    task automatic test_async_reset();
        iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        step();
        n_vec++;
        if ({ov8, co8, s8} !== 10'h246) begin
            n_err++;
            $display("FAIL async_pre: got v/c/s=%h expected 246", {ov8, co8, s8});
        end
        a8 = 8'h01; b8 = 8'h02;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ov8, co8, s8} !== 10'h000) begin
            n_err++;
            $display("FAIL async_clear: got v/c/s=%h expected 000", {ov8, co8, s8});
        end
        iv8 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({ov8, co8, s8} !== 10'h000) begin
            n_err++;
            $display("FAIL async_no_stale: got v/c/s=%h expected 000", {ov8, co8, s8});
        end
        iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        step();
        n_vec++;
        if ({ov8, co8, s8} !== 10'h246) begin
            n_err++;
            $display("FAIL async_fresh: got v/c/s=%h expected 246", {ov8, co8, s8});
        end
        iv8 = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_truth_table();
        test_hold();
        test_wrap_w8();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered, parameterizable ripple-carry full adder: computes {carry, sum} = a + b + c, with c as the 1-bit carry-in.
- Built as a chain of 1-bit full-adder cells, with one output register stage and a valid qualifier.
- Used as a leaf arithmetic primitive inside datapaths. The WIDTH=1 default is the classic 1-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/c are valid this cycle
- a  input  WIDTH  operand A (unsigned; two's complement when the optional feature is used)
- b  input  WIDTH  operand B
- c  input  1  carry-in
- sum  output  WIDTH  registered sum bits
- carry  output  1  registered carry-out (MSB of the WIDTH+1 result)
- out_valid  output  1  sum/carry updated from an accepted input on the previous edge

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces sum=0, carry=0, out_valid=0 (and ovf=0 if present). Release is sampled at the next rising clk.
- Combinational core: ripple chain of WIDTH fa_cell instances.
  - Cell i: s_i = a_i ^ b_i ^ cin_i; cout_i = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i).
  - cin_0 = c; cout_(WIDTH-1) drives the carry register.
- Latency: exactly 1 cycle. At a rising edge with in_valid=1, sum and carry capture the core result and out_valid=1 on the following cycle.
- in_valid=0 at an edge: sum/carry hold their previous values; out_valid=0.
- Back-to-back in_valid=1 is accepted every cycle (throughput 1/cycle); no backpressure.
- Arithmetic wraps modulo 2^WIDTH in sum; overflow beyond WIDTH bits appears only on carry.
- WIDTH=1 truth table (a,b,c -> carry,sum):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- X/Z on inputs while in_valid=0 must not propagate to the outputs.
- Reset asserted mid-stream: any in-flight result is discarded; first out_valid after release needs a fresh in_valid edge.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ovf = cin_(WIDTH-1) ^ cout_(WIDTH-1): signed two's-complement overflow.
  - Captured and held under the same in_valid rules as sum.
- Not defined: no ovf port and no extra logic. All other behaviour is identical.

Decomposition:
- Package full_adder_pkg holds:
  - constant FA_DEFAULT_WIDTH = 1;
  - constant FA_MAX_WIDTH = 64;
  - typedef of a packed result struct {carry, sum}, parameterized via localparam at the use site.
- Sub-module fa_cell: 1-bit combinational full adder (a, b, cin -> s, cout). It is instantiated WIDTH times via generate.
- The top level holds the output registers, valid logic and the optional ovf.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=b=c=1 -> sum=0, carry=0, out_valid=0 throughout. Deassert; next edge with inputs 1,1,1 -> carry=1, sum=1, out_valid=1.
- WIDTH=1 exhaustive: apply all 8 {a,b,c} combinations, one per cycle, with in_valid=1 -> each output matches the truth table one cycle later; out_valid stays 1.
- Hold: accept a=1,b=0,c=1 (-> carry=1, sum=0), then in_valid=0 for 3 cycles with random a/b/c -> outputs unchanged, out_valid=0.
- WIDTH=8 wrap: a=8'hFF, b=8'h00, c=1 -> sum=8'h00, carry=1. Then a=8'h80, b=8'h80, c=0 -> sum=8'h00, carry=1.
- Async reset mid-stream (WIDTH=8): drive rst_n low between edges after a=8'h12, b=8'h34, c=0 is accepted -> outputs clear immediately (not at the next edge); no stale out_valid after release.
- FULL_ADDER_OVF_EN, WIDTH=8:
  - a=8'h7F, b=8'h01, c=0 -> sum=8'h80, carry=0, ovf=1.
  - a=8'hFF, b=8'h01, c=0 -> sum=8'h00, carry=1, ovf=0.
